// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register chain with valid, stall, flush and perf counters
// Ports: CLK (state updates on falling edge), RSTn (async active-low reset),
//   stall/flush (hold / squash all stages), in_valid/in_ctrl/in_data (upstream entry),
//   cnt_clr (sync counter clear), out_valid/out_ctrl/out_data (last stage),
//   stall_cnt/bubble_cnt (saturating stall-edge and last-stage bubble counts)
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic [DEPTH-1:0]  v;
  logic [CTRL_W-1:0] c [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];
  logic [DEPTH-1:0]  nv;
  logic              adv;
  // valid bits each stage would load on an advance: s0 from input, s[k] from s[k-1]
  assign nv  = DEPTH'({v, in_valid});
  assign adv = ~stall & ~flush;
  always_ff @(negedge CLK or negedge RSTn)
    if (!RSTn) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c[i] <= '0;
        d[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) c[i] <= '0;
    end else if (!stall) begin
      v    <= nv;
      c[0] <= in_valid ? in_ctrl : '0;
      d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        c[i] <= c[i-1];
        d[i] <= d[i-1];
      end
    end
  always_ff @(negedge CLK or negedge RSTn)
    if (!RSTn) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt  <= cnt_clr ? '0 : (stall && !flush && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
      bubble_cnt <= cnt_clr ? '0 : (adv && !nv[DEPTH-1] && !(&bubble_cnt)) ? bubble_cnt + 1'b1 : bubble_cnt;
    end
  assign out_valid = v[DEPTH-1];
  assign out_ctrl  = c[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed per-boundary latches between processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic control vector and data vector through a configurable number of register stages. It adds a valid bit, a global stall (hold), and a flush (squash to bubble) that forces control bits to zero. It also keeps saturating stall and bubble counters for performance debug.

## Interface
Parameters:
- DATA_W, 160, width of the data vector (ALU result, addresses, write data, next PC, …), ≥1
- CTRL_W, 8, width of the control vector (RegWrite, MemWrite, MemRead, MemtoReg, Branch, …), ≥1
- DEPTH, 1, number of register stages in the chain, 1..4
- CNT_W, 16, width of each performance counter, ≥2

Ports:
- CLK  in  1  pipeline clock; all state updates on the falling edge
- RSTn  in  1  reset, asynchronous, active-low
- stall  in  1  hold all stages this edge
- flush  in  1  squash all stages to bubbles this edge
- in_valid  in  1  entry at input is a real instruction
- in_ctrl  in  CTRL_W  control vector from the upstream stage
- in_data  in  DATA_W  data vector from the upstream stage
- cnt_clr  in  1  synchronous clear of both counters
- out_valid  out  1  valid bit of the last stage
- out_ctrl  out  CTRL_W  control vector of the last stage; always zero when out_valid=0
- out_data  out  DATA_W  data vector of the last stage
- stall_cnt  out  CNT_W  saturating count of stalled edges
- bubble_cnt  out  CNT_W  saturating count of bubbles loaded into the last stage

## Operation
- Stages are numbered s0 (input side) to s[DEPTH-1], which drives the outputs. Each stage holds valid, ctrl and data.
- Priority on each falling edge is flush > stall > advance.
- Flush: every stage gets valid=0 and ctrl=0, and data is held. Input is not captured. stall is ignored.
- Stall (flush=0): every stage holds all fields. The input is dropped; the upstream stage is responsible for holding it.
- Advance (stall=0, flush=0):
  - s0 loads valid=in_valid, data=in_data, and ctrl=in_valid ? in_ctrl : 0.
  - s[k] loads s[k-1] for k≥1.
- Invariant: ctrl of any stage with valid=0 is all zeros. This guarantees a bubble never writes the register file or memory.
- stall_cnt: +1 on each edge with stall=1 and flush=0. It saturates at 2^CNT_W−1.
- bubble_cnt: +1 on each advance edge where s[DEPTH-1] loads valid=0, including when DEPTH=1 and in_valid=0. Flush edges do not count. It saturates at 2^CNT_W−1.
- cnt_clr=1 zeroes both counters on that edge and takes priority over increments. cnt_clr does not affect the pipeline.
- Reset (RSTn=0) asynchronously sets every valid, ctrl, data and counter to 0. Outputs read 0 while RSTn=0.

## Timing
- Latency is DEPTH falling edges from in_* to out_*, excluding stalled edges. Flushed entries never emerge.
- Outputs are registered with no combinational path from any input to any output.
- RSTn assertion takes effect immediately, with no CLK needed. The first state update is on the first falling edge with RSTn=1.
- If reset is asserted mid-stream, in-flight entries are lost and the counters restart at 0.
- stall and flush asserted together are treated as a flush, and stall_cnt does not increment.
- A stall held for many cycles holds out_* constant, and stall_cnt counts each edge until it saturates and then stays saturated.
- With cnt_clr=1 and a saturated counter, the counter reads 0 after the edge.

## Test plan
- Reset: drive random inputs and pulse RSTn low between edges. All outputs read 0 immediately and stay 0 until the first falling edge after release.
- Pass-through, DEPTH=2: apply valid entries A (data 0x11, ctrl 0x05) then B (data 0x22, ctrl 0x0A) on consecutive edges. A appears on out_* after edge 2 and B after edge 3, both with out_valid=1. bubble_cnt stays 0 in steady state.
- Bubble squash: in_valid=0 with in_ctrl=0xFF. After DEPTH edges out_valid=0 and out_ctrl=0x00, and bubble_cnt increments by 1.
- Stall: with A in s1, hold stall=1 for 3 edges. out_* is held at A, stall_cnt=3, and B presented at the input during the stall is not captured.
- Flush over stall: with stall=1 and flush=1 together on one edge, every stage has valid=0 and ctrl=0 afterwards, out_data is unchanged, and stall_cnt is unchanged.
- Counter saturation and clear, CNT_W=2: apply 5 stall edges. stall_cnt reads 3. One edge with cnt_clr=1 and stall=1 gives stall_cnt=0.
